// File: rtl/ras_ctrl_if.sv
// rtl/ras_ctrl_if.sv - pipeline-side and RAS-side signals of the call/return speculation tracker
interface ras_ctrl_if #(
  parameter int CNT_WIDTH = 8
);
  logic [31:0]          if_instr;
  logic                 if_valid;
  logic                 stall;
  logic                 flush_id;
  logic                 flush_ex;
  logic                 push;
  logic                 pop;
  logic                 rollback_pop_id;
  logic                 rollback_push_id;
  logic                 rollback_push_ex;
  logic [CNT_WIDTH-1:0] desync_cnt;

  modport master (
    output if_instr, if_valid, stall, flush_id, flush_ex,
    input  push, pop, rollback_pop_id, rollback_push_id, rollback_push_ex, desync_cnt
  );

  modport slave (
    input  if_instr, if_valid, stall, flush_id, flush_ex,
    output push, pop, rollback_pop_id, rollback_push_id, rollback_push_ex, desync_cnt
  );
endinterface

// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - classifies calls/returns in IF, issues RAS push/pop, tracks them to EX for rollback
module ras_ctrl #(
  parameter int CNT_WIDTH = 8,
  parameter bit LINK_X5   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  ras_ctrl_if.slave  bus
);

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [2:0] funct3;
  logic       rd_link;
  logic       rs1_link;
  logic       cls_push;
  logic       cls_pop;
  logic       any_flush;
  logic       adv;

  logic                 id_push_q, id_push_d;
  logic                 id_pop_q,  id_pop_d;
  logic                 ex_push_q, ex_push_d;
  logic                 ex_pop_q,  ex_pop_d;
  logic [CNT_WIDTH-1:0] desync_cnt_q, desync_cnt_d;

  assign opcode = bus.if_instr[6:0];
  assign rd     = bus.if_instr[11:7];
  assign funct3 = bus.if_instr[14:12];
  assign rs1    = bus.if_instr[19:15];

  assign rd_link  = (rd == 5'd1)  || (LINK_X5 && (rd == 5'd5));
  assign rs1_link = (rs1 == 5'd1) || (LINK_X5 && (rs1 == 5'd5));

  // A JALR with both rd and rs1 linked would be a coroutine swap; it is treated as a plain call.
  always_comb begin
    cls_push = 1'b0;
    cls_pop  = 1'b0;
    if (opcode == OPC_JAL) begin
      cls_push = rd_link;
    end else if ((opcode == OPC_JALR) && (funct3 == 3'b000)) begin
      cls_push = rd_link;
      cls_pop  = !rd_link && rs1_link;
    end
  end

  assign any_flush = bus.flush_id | bus.flush_ex;
  assign adv       = bus.if_valid & !bus.stall & !any_flush & !rst;

  assign bus.push = adv & cls_push;
  assign bus.pop  = adv & cls_pop;

  // Flushes block adv, so a rollback never coincides with a forward push/pop.
  assign bus.rollback_pop_id  = !rst & any_flush   & id_pop_q;
  assign bus.rollback_push_id = !rst & any_flush   & id_push_q;
  assign bus.rollback_push_ex = !rst & bus.flush_ex & ex_push_q;
  assign bus.desync_cnt       = desync_cnt_q;

  always_comb begin
    id_push_d    = id_push_q;
    id_pop_d     = id_pop_q;
    ex_push_d    = 1'b0;
    ex_pop_d     = 1'b0;
    desync_cnt_d = desync_cnt_q;
    if (any_flush) begin
      id_push_d = 1'b0;
      id_pop_d  = 1'b0;
    end else if (!bus.stall) begin
      id_push_d = bus.push;
      id_pop_d  = bus.pop;
      ex_push_d = id_push_q;
      ex_pop_d  = id_pop_q;
    end
    // A killed pop that already left ID cannot be repaired by the RAS; only count it.
    if (bus.flush_ex && ex_pop_q && (desync_cnt_q != {CNT_WIDTH{1'b1}})) begin
      desync_cnt_d = desync_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_push_q    <= 1'b0;
      id_pop_q     <= 1'b0;
      ex_push_q    <= 1'b0;
      ex_pop_q     <= 1'b0;
      desync_cnt_q <= '0;
    end else begin
      id_push_q    <= id_push_d;
      id_pop_q     <= id_pop_d;
      ex_push_q    <= ex_push_d;
      ex_pop_q     <= ex_pop_d;
      desync_cnt_q <= desync_cnt_d;
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// tb/tb_ras_ctrl.sv - directed self-checking bench for ras_ctrl
module tb_ras_ctrl;
  localparam logic [31:0] JAL_X1    = 32'h000000EF;
  localparam logic [31:0] RET       = 32'h00008067;
  localparam logic [31:0] JALR_1_5  = 32'h000280E7;
  localparam logic [31:0] JALR_5_5  = 32'h000282E7;
  localparam logic [31:0] NOP       = 32'h00000013;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  ras_ctrl_if #(.CNT_WIDTH(8)) bus ();
  ras_ctrl_if #(.CNT_WIDTH(8)) bus2 ();

  ras_ctrl #(.CNT_WIDTH(8), .LINK_X5(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  ras_ctrl #(.CNT_WIDTH(8), .LINK_X5(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus2.if_instr = bus.if_instr;
  assign bus2.if_valid = bus.if_valid;
  assign bus2.stall    = bus.stall;
  assign bus2.flush_id = bus.flush_id;
  assign bus2.flush_ex = bus.flush_ex;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic valid, input logic stl,
                       input logic fid, input logic fex);
    bus.if_instr = instr;
    bus.if_valid = valid;
    bus.stall    = stl;
    bus.flush_id = fid;
    bus.flush_ex = fex;
    #1;
  endtask

  task automatic idle2();
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    drive(JAL_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_push", {31'd0, bus.push}, 32'd0);
    check("rst_cnt", {24'd0, bus.desync_cnt}, 32'd0);
    check("rst_id_push", {31'd0, dut.id_push_q}, 32'd0);

    // basic call: push now, ID next, EX after
    step();
    rst = 1'b0;
    #1;
    check("jal_push", {31'd0, bus.push}, 32'd1);
    check("jal_pop", {31'd0, bus.pop}, 32'd0);
    step();
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    check("jal_id_push", {31'd0, dut.id_push_q}, 32'd1);
    check("jal_ex_push_early", {31'd0, dut.ex_push_q}, 32'd0);
    check("jal_pop_id", {31'd0, bus.pop}, 32'd0);
    step();
    check("jal_ex_push", {31'd0, dut.ex_push_q}, 32'd1);
    check("jal_id_clear", {31'd0, dut.id_push_q}, 32'd0);

    // classification
    drive(RET, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ret_pop", {31'd0, bus.pop}, 32'd1);
    check("ret_push", {31'd0, bus.push}, 32'd0);
    drive(JALR_1_5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("jalr15_push", {31'd0, bus.push}, 32'd1);
    check("jalr15_pop", {31'd0, bus.pop}, 32'd0);
    drive(JALR_5_5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("jalr55_push", {31'd0, bus.push}, 32'd1);
    check("jalr55_pop", {31'd0, bus.pop}, 32'd0);
    check("x5off_push", {31'd0, bus2.push}, 32'd0);
    check("x5off_pop", {31'd0, bus2.pop}, 32'd0);
    drive(RET, 1'b1, 1'b0, 1'b0, 1'b0);
    check("x5off_ret_pop", {31'd0, bus2.pop}, 32'd1);
    idle2();

    // call in ID killed by flush_id; a call in IF must not push
    drive(JAL_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(JAL_X1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("fid_rb_push_id", {31'd0, bus.rollback_push_id}, 32'd1);
    check("fid_push", {31'd0, bus.push}, 32'd0);
    check("fid_rb_push_ex", {31'd0, bus.rollback_push_ex}, 32'd0);
    step();
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fid_id_clear", {30'd0, dut.id_push_q, dut.id_pop_q}, 32'd0);
    check("fid_ex_clear", {30'd0, dut.ex_push_q, dut.ex_pop_q}, 32'd0);
    idle2();

    // ret in ID, call in EX, flush_ex: offset-0 rollback pair
    drive(JAL_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(RET, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b1);
    check("fex_rb_pop_id", {31'd0, bus.rollback_pop_id}, 32'd1);
    check("fex_rb_push_ex", {31'd0, bus.rollback_push_ex}, 32'd1);
    check("fex_rb_push_id", {31'd0, bus.rollback_push_id}, 32'd0);
    step();
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fex_cnt", {24'd0, bus.desync_cnt}, 32'd0);
    check("fex_state", {28'd0, dut.id_push_q, dut.id_pop_q, dut.ex_push_q, dut.ex_pop_q}, 32'd0);
    idle2();

    // ret in EX killed: no rollback, counter bumps then saturates
    for (int i = 1; i <= 300; i++) begin
      drive(RET, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(NOP, 1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 1) begin
        check("desync_rb", {29'd0, bus.rollback_pop_id, bus.rollback_push_id,
                            bus.rollback_push_ex}, 32'd0);
      end
      step();
      drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 1)   check("desync_1", {24'd0, bus.desync_cnt}, 32'd1);
      if (i == 255) check("desync_255", {24'd0, bus.desync_cnt}, 32'd255);
      if (i == 256) check("desync_sat", {24'd0, bus.desync_cnt}, 32'd255);
    end
    check("desync_300", {24'd0, bus.desync_cnt}, 32'd255);
    idle2();

    // stall + flush together: flush wins
    drive(JAL_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(JAL_X1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("stlflush_rb", {31'd0, bus.rollback_push_id}, 32'd1);
    check("stlflush_push", {31'd0, bus.push}, 32'd0);
    step();
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stlflush_id", {31'd0, dut.id_push_q}, 32'd0);
    idle2();

    // call in IF stalled three cycles behind a call in ID
    drive(JAL_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(JAL_X1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("stall_push", {31'd0, bus.push}, 32'd0);
      check("stall_id_hold", {31'd0, dut.id_push_q}, 32'd1);
      step();
      check("stall_ex_bubble", {31'd0, dut.ex_push_q}, 32'd0);
    end
    drive(JAL_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("unstall_push", {31'd0, bus.push}, 32'd1);
    step();
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    check("unstall_ex", {31'd0, dut.ex_push_q}, 32'd1);
    check("unstall_id", {31'd0, dut.id_push_q}, 32'd1);
    step();
    check("unstall_once", {31'd0, dut.id_push_q}, 32'd0);

    // async reset mid-stall with a flush pending
    drive(JAL_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(JAL_X1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    #2;
    rst = 1'b1;
    bus.flush_ex = 1'b1;
    #1;
    check("arst_id", {31'd0, dut.id_push_q}, 32'd0);
    check("arst_cnt", {24'd0, bus.desync_cnt}, 32'd0);
    check("arst_rb", {29'd0, bus.rollback_pop_id, bus.rollback_push_id,
                      bus.rollback_push_ex}, 32'd0);
    check("arst_push", {30'd0, bus.push, bus.pop}, 32'd0);
    step();
    rst = 1'b0;
    drive(JAL_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_rst_push", {31'd0, bus.push}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Call/return classifier and speculation tracker that drives the return-address stack's `push`, `pop` and rollback inputs. It predecodes the instruction in IF and issues push/pop as the instruction leaves IF. It carries each issued action through ID and EX. When a flush kills an instruction whose action was already applied, it issues the matching rollback.

## Interface
Parameters:
- `CNT_WIDTH`, 8, width of the saturating unrecoverable-event counter.
- `LINK_X5`, 1, when 1 both x1 and x5 are link registers; when 0 only x1 is.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_instr`  in  32  instruction currently in IF.
- `if_valid`  in  1  `if_instr` is a real fetched instruction.
- `stall`  in  1  IF and ID hold; EX receives a bubble.
- `flush_id`  in  1  kill the instruction in ID (and the one in IF).
- `flush_ex`  in  1  kill the instruction in EX (and those in ID and IF).
- `push`  out  1  to RAS: push `pc_add_4`.
- `pop`  out  1  to RAS: pop.
- `rollback_pop_id`  out  1  undo the pop of the killed ID instruction.
- `rollback_push_id`  out  1  undo the push of the killed ID instruction.
- `rollback_push_ex`  out  1  undo the push of the killed EX instruction.
- `desync_cnt`  out  CNT_WIDTH  saturating count of unrecoverable EX pops killed.

## Operation
- Link register test: rd/rs1 equals 1, or equals 5 when `LINK_X5`=1.
- Predecode (combinational on `if_instr`):
  - opcode 1101111 (JAL): `cls_push` = rd is link.
  - opcode 1100111 with funct3 000 (JALR):
    - rd link → `cls_push`, in all rs1 cases; coroutine pop+push is not supported, push wins.
    - rd not link, rs1 link → `cls_pop`.
    - neither is link → no action.
  - All other encodings → no action.
- Issue condition: `adv = if_valid & !stall & !flush_id & !flush_ex & !rst`.
  - `push = adv & cls_push`, `pop = adv & cls_pop`.
  - `push` and `pop` are never both 1.
- Tracking state:
  - `id_push`, `id_pop` latch the issued action when IF advances; hold on `stall`.
  - `ex_push`, `ex_pop` latch `id_*` each cycle; cleared on `stall` (bubble).
- Flush effects on state:
  - `flush_id` clears `id_*` at the next edge; `ex_*` loads 0.
  - `flush_ex` clears `id_*` and `ex_*`.
- Rollback outputs (combinational):
  - `rollback_pop_id = (flush_id|flush_ex) & id_pop`.
  - `rollback_push_id = (flush_id|flush_ex) & id_push`.
  - `rollback_push_ex = flush_ex & ex_push`.
- `flush_ex & ex_pop` cannot be undone by the RAS. It increments `desync_cnt`, which saturates at all-ones.
- Any rollback active implies `push = pop = 0`, because `adv` is 0 under any flush. This guarantees the RAS offset mux never sees a forward action together with a rollback.
- Legal rollback combinations to the RAS: `pop_id+push_ex` (offset 0), `push_id+push_ex` (+2), any single rollback.

## Timing
- Reset (async assert) clears `id_*`, `ex_*` and `desync_cnt` to 0, and forces `push`, `pop` and all rollbacks to 0. Deassertion is synchronous to `clk` (two-flop synchroniser outside this block).
- Latency:
  - `push`/`pop`: 0 cycles from `if_instr`.
  - Rollbacks: 0 cycles from the flush input.
  - `desync_cnt` updates 1 cycle after the event.
- An action issued in cycle N is visible as `id_*` in N+1 and as `ex_*` in N+2, absent stalls.
- Stall held k cycles:
  - Exactly one push/pop is issued per instruction, on the cycle `stall` drops.
  - The `id_*` flag persists through the stall.
- `flush_id` and `flush_ex` together behave as `flush_ex`.
- `stall` together with a flush: the flush wins; state is cleared.
- Reset mid-flush: reset wins; no rollback is issued.

## Test plan
- JAL x1 `0x000000EF`, valid, no stall → `push`=1 that cycle. `id_push`=1 next cycle, `ex_push`=1 the cycle after. `pop`=0 throughout.
- `ret` `0x00008067` → `pop`=1. JALR x1,0(x5) `0x000280E7` → `push`=1 only. JALR x5,0(x5) `0x000282E7` → `push`=1. With `LINK_X5`=0, `0x000282E7` → no action.
- Call in ID, `flush_id` pulse → `rollback_push_id`=1, `push`=0 that cycle. ID and EX flags are 0 next cycle.
- Ret in ID with a call in EX, `flush_ex` pulse → `rollback_pop_id`=1 and `rollback_push_ex`=1 in the same cycle. `desync_cnt` unchanged.
- Ret in EX, `flush_ex` → no rollback. `desync_cnt` goes 0→1; after 300 such events it reads 255 (`CNT_WIDTH`=8).
- Call in IF with `stall`=1 for 3 cycles → `push`=0 for 3 cycles, then 1 for one cycle. `ex_push`=0 during the stall; async `rst` mid-stall clears all state immediately.
